// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, frames 11-bit
// serial bytes and decodes Set-2 make/break sequences into Hack key codes.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             fall_c;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             ext_q, ext_d, brk_q, brk_d;
  logic [7:0]       out_q, out_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       code_c;

  // Set-2 scan code (with E0 prefix flag) to Hack key code; 0 means unmapped.
  function automatic logic [7:0] translate(input logic ext, input logic [7:0] sc);
    case ({ext, sc})
      9'h01C: return 8'd65;  9'h032: return 8'd66;  9'h021: return 8'd67;
      9'h023: return 8'd68;  9'h024: return 8'd69;  9'h02B: return 8'd70;
      9'h034: return 8'd71;  9'h033: return 8'd72;  9'h043: return 8'd73;
      9'h03B: return 8'd74;  9'h042: return 8'd75;  9'h04B: return 8'd76;
      9'h03A: return 8'd77;  9'h031: return 8'd78;  9'h044: return 8'd79;
      9'h04D: return 8'd80;  9'h015: return 8'd81;  9'h02D: return 8'd82;
      9'h01B: return 8'd83;  9'h02C: return 8'd84;  9'h03C: return 8'd85;
      9'h02A: return 8'd86;  9'h01D: return 8'd87;  9'h022: return 8'd88;
      9'h035: return 8'd89;  9'h01A: return 8'd90;
      9'h045: return 8'd48;  9'h016: return 8'd49;  9'h01E: return 8'd50;
      9'h026: return 8'd51;  9'h025: return 8'd52;  9'h02E: return 8'd53;
      9'h036: return 8'd54;  9'h03D: return 8'd55;  9'h03E: return 8'd56;
      9'h046: return 8'd57;
      9'h029: return 8'd32;  9'h05A: return 8'd128; 9'h066: return 8'd129;
      9'h076: return 8'd140;
      9'h16B: return 8'd130; 9'h175: return 8'd131; 9'h174: return 8'd132;
      9'h172: return 8'd133; 9'h16C: return 8'd134; 9'h169: return 8'd135;
      9'h171: return 8'd139;
      default: return 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      out_q        <= '0;
      strobe_q     <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      data_s1_q    <= ps2_data;
      data_s2_q    <= data_s1_q;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      out_q        <= out_d;
      strobe_q     <= strobe_d;
    end
  end

  // Level filter: the bit event fires in the cycle the FILTER_LEN-th low sample arrives.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_c = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall_c = filt_q;
      end else begin
        fcnt_d = fcnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    tmo_d        = tmo_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q != ST_IDLE) tmo_d = tmo_q + TMO_W'(1);
    if (fall_c) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d = {data_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = ST_PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, data_s2_q};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (data_s2_q && par_ok_q) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = ST_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end
  end

  // Decoder: E0/F0 prefixes are latched until the next code byte or a frame error.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    code_c   = translate(ext_q, byte_q);
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (code_c != 8'd0) begin
          if (!brk_q) begin
            if (code_c != out_q) begin
              out_d    = code_c;
              strobe_d = 1'b1;
            end
          end else if (code_c == out_q) begin
            out_d    = 8'd0;
            strobe_d = 1'b1;
          end
        end
      end
    end
  end

  assign out        = {8'h00, out_q};
  assign key_strobe = strobe_q;
  assign frame_err  = frame_err_q;

endmodule
